// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and constants for count_up_down_mod: the
//               overflow-mode encoding and its width.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    // Encoding 2'b11 is not listed and behaves as wrap.
    localparam mode_t MODE_WRAP    = 2'b00;
    localparam mode_t MODE_SAT     = 2'b01;
    localparam mode_t MODE_ONESHOT = 2'b10;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Prescaler. Counts enabled, non-cleared cycles from 0 to
//               PRESCALE-1 and emits a single-cycle tick on the last one.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               en   - advance the prescaler this cycle
//               clr  - restart the interval (takes priority over en)
//               tick - combinational, high on the cycle that completes it
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            c_CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(PRESCALE - 1);

    logic [c_CW-1:0] r_cnt;
    logic            w_last;

    assign w_last = (r_cnt == c_LAST);
    assign tick   = en && !clr && w_last;

    // With PRESCALE=1 c_LAST is 0, so r_cnt never leaves 0 and every
    // enabled cycle ticks.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + c_CW'(1);
        end
    end

endmodule : tick_gen
`default_nettype wire

// File: rtl/count_up_down_mod.sv
`default_nettype none
// ============================================================================
// Module      : count_up_down_mod
// Description : Up/down counter over 0..MOD_MAX with programmable step,
//               prescaler and overflow mode (wrap, saturate, one-shot).
// Ports       : clk, rst       - clock, synchronous active-high reset
//               en             - count enable (gates the prescaler)
//               up_not_down    - 1 = up, 0 = down
//               load, data     - load count with min(data, MOD_MAX)
//               step           - amount per tick, clamped to MOD_MAX
//               mode           - overflow behaviour (counter_pkg encoding)
//               count          - registered count
//               tc             - 1-cycle pulse when the last tick crossed a bound
//               done           - sticky, one-shot stopped at a bound
// Revision    : 1.0 - initial release
// ============================================================================
module count_up_down_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MOD_MAX  = 255,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_not_down,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] step,
    input  mode_t            mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_MODW = MOD_MAX[WIDTH-1:0];
    localparam logic [WIDTH:0]   c_MOD  = {1'b0, c_MODW};

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_done;

    logic             w_tick;
    logic [WIDTH-1:0] w_stp;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH:0]   w_sum;
    logic             w_over;
    logic             w_under;
    logic             w_hold;
    logic             w_oneshot;
    logic [WIDTH-1:0] w_wrap_up;
    logic [WIDTH-1:0] w_wrap_dn;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_done_nxt;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (w_tick)
    );

    assign w_stp      = ({1'b0, step} > c_MOD) ? c_MODW : step;
    assign w_load_val = ({1'b0, data} > c_MOD) ? c_MODW : data;

    // One extra bit so the up-overflow test cannot alias.
    assign w_sum   = {1'b0, r_count} + {1'b0, w_stp};
    assign w_over  = (w_sum > c_MOD);
    assign w_under = (w_stp > r_count);

    // Both wrapped results lie in 0..MOD_MAX, so modulo-2**WIDTH arithmetic
    // yields the exact value without needing the carry bit.
    assign w_wrap_up = r_count + w_stp - c_MODW - WIDTH'(1);
    assign w_wrap_dn = r_count + c_MODW + WIDTH'(1) - w_stp;

    assign w_oneshot = (mode == MODE_ONESHOT);
    assign w_hold    = (mode == MODE_SAT) || w_oneshot;

    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_done_nxt  = r_done;
        if (load) begin
            w_count_nxt = w_load_val;
            w_done_nxt  = 1'b0;
        end else if (w_tick && !r_done && (w_stp != '0)) begin
            if (up_not_down) begin
                if (w_over) begin
                    w_tc_nxt    = 1'b1;
                    w_count_nxt = w_hold ? c_MODW : w_wrap_up;
                    w_done_nxt  = w_oneshot;
                end else begin
                    w_count_nxt = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_under) begin
                    w_tc_nxt    = 1'b1;
                    w_count_nxt = w_hold ? '0 : w_wrap_dn;
                    w_done_nxt  = w_oneshot;
                end else begin
                    w_count_nxt = r_count - w_stp;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign done  = r_done;

endmodule : count_up_down_mod
`default_nettype wire

// File: tb/tb_count_up_down_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_up_down_mod
// Description : Self-checking bench. Three counter instances share one
//               stimulus stream; a behavioural model per instance is compared
//               every cycle, plus directed sequences with literal results.
//               Instance 0: MOD_MAX=255 PRESCALE=1
//               Instance 1: MOD_MAX=9   PRESCALE=1
//               Instance 2: MOD_MAX=99  PRESCALE=4
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_up_down_mod;

    localparam int c_N = 3;
    localparam int c_MM[c_N] = '{255, 9, 99};
    localparam int c_PS[c_N] = '{1, 1, 4};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_not_down = 1'b1;
    logic       load = 1'b0;
    logic [7:0] data = 8'd0;
    logic [7:0] step = 8'd0;
    logic [1:0] mode = 2'b00;

    logic [7:0] cnt  [c_N];
    logic       tcv  [c_N];
    logic       dnv  [c_N];

    int checks   = 0;
    int failures = 0;

    int m_count [c_N];
    int m_tc    [c_N];
    int m_done  [c_N];
    int m_pre   [c_N];

    always #5 clk = ~clk;

    count_up_down_mod #(.WIDTH(8), .MOD_MAX(255), .PRESCALE(1)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .up_not_down(up_not_down), .load(load),
        .data(data), .step(step), .mode(mode),
        .count(cnt[0]), .tc(tcv[0]), .done(dnv[0]));

    count_up_down_mod #(.WIDTH(8), .MOD_MAX(9), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .up_not_down(up_not_down), .load(load),
        .data(data), .step(step), .mode(mode),
        .count(cnt[1]), .tc(tcv[1]), .done(dnv[1]));

    count_up_down_mod #(.WIDTH(8), .MOD_MAX(99), .PRESCALE(4)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .up_not_down(up_not_down), .load(load),
        .data(data), .step(step), .mode(mode),
        .count(cnt[2]), .tc(tcv[2]), .done(dnv[2]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one clock of the counter rules using plain integers.
    function automatic void model_step(input int k);
        int mm, stp, s;
        bit tick, hold, oneshot;
        mm = c_MM[k];
        if (rst) begin
            m_count[k] = 0; m_tc[k] = 0; m_done[k] = 0; m_pre[k] = 0;
            return;
        end
        m_tc[k] = 0;
        if (load) begin
            m_count[k] = (int'(data) > mm) ? mm : int'(data);
            m_done[k]  = 0;
            m_pre[k]   = 0;
            return;
        end
        tick = 0;
        if (en) begin
            if (m_pre[k] == c_PS[k] - 1) begin
                tick = 1; m_pre[k] = 0;
            end else begin
                m_pre[k]++;
            end
        end
        if (!tick || m_done[k] != 0) return;
        stp = (int'(step) > mm) ? mm : int'(step);
        if (stp == 0) return;
        oneshot = (mode == 2'b10);
        hold    = (mode == 2'b01) || oneshot;
        if (up_not_down) begin
            s = m_count[k] + stp;
            if (s > mm) begin
                m_tc[k] = 1;
                if (hold) m_count[k] = mm;
                else      m_count[k] = s - (mm + 1);
                if (oneshot) m_done[k] = 1;
            end else begin
                m_count[k] = s;
            end
        end else begin
            if (stp > m_count[k]) begin
                m_tc[k] = 1;
                if (hold) m_count[k] = 0;
                else      m_count[k] = m_count[k] + (mm + 1) - stp;
                if (oneshot) m_done[k] = 1;
            end else begin
                m_count[k] = m_count[k] - stp;
            end
        end
    endfunction

    // Model advance and per-cycle comparison of every instance.
    always @(posedge clk) begin
        for (int k = 0; k < c_N; k++) model_step(k);
        #1;
        for (int k = 0; k < c_N; k++) begin
            chk($sformatf("model_count[%0d]", k), int'(cnt[k]), m_count[k]);
            chk($sformatf("model_tc[%0d]", k),    int'(tcv[k]), m_tc[k]);
            chk($sformatf("model_done[%0d]", k),  int'(dnv[k]), m_done[k]);
        end
    end

    // Apply one cycle of inputs; returns 2 time units after the edge.
    task automatic cyc(input logic r, input logic e, input logic u,
                       input logic l, input logic [7:0] d,
                       input logic [7:0] s, input logic [1:0] m);
        @(negedge clk);
        rst = r; en = e; up_not_down = u; load = l; data = d; step = s; mode = m;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset
        cyc(1, 0, 1, 0, 8'd0, 8'd0, 2'b00);
        chk("reset_count", int'(cnt[0]), 0);
        chk("reset_done", int'(dnv[0]), 0);

        // rst wins mid-count and over load
        cyc(0, 0, 1, 1, 8'h37, 8'd1, 2'b00);
        chk("load_37", int'(cnt[0]), 8'h37);
        cyc(1, 1, 1, 1, 8'h55, 8'd1, 2'b00);
        chk("rst_mid_count", int'(cnt[0]), 0);
        chk("rst_mid_tc", int'(tcv[0]), 0);
        chk("rst_mid_done", int'(dnv[0]), 0);

        // Down regression: 10 -> 9, 8, 7
        cyc(0, 0, 0, 1, 8'd10, 8'd1, 2'b00);
        cyc(0, 1, 0, 0, 8'd0, 8'd1, 2'b00); chk("down_9", int'(cnt[0]), 9);
        cyc(0, 1, 0, 0, 8'd0, 8'd1, 2'b00); chk("down_8", int'(cnt[0]), 8);
        cyc(0, 1, 0, 0, 8'd0, 8'd1, 2'b00); chk("down_7", int'(cnt[0]), 7);

        // Wrap with MOD_MAX=9 (instance 1)
        cyc(0, 0, 1, 1, 8'd8, 8'd3, 2'b00);
        cyc(0, 1, 1, 0, 8'd0, 8'd3, 2'b00);
        chk("wrap_up_count", int'(cnt[1]), 1);
        chk("wrap_up_tc", int'(tcv[1]), 1);
        cyc(0, 0, 1, 0, 8'd0, 8'd3, 2'b00);
        chk("wrap_tc_pulse", int'(tcv[1]), 0);
        cyc(0, 1, 0, 0, 8'd0, 8'd3, 2'b00);
        chk("wrap_dn_count", int'(cnt[1]), 8);
        chk("wrap_dn_tc", int'(tcv[1]), 1);

        // Saturate (instance 0)
        cyc(0, 0, 1, 1, 8'd254, 8'd5, 2'b01);
        cyc(0, 1, 1, 0, 8'd0, 8'd5, 2'b01);
        chk("sat_up_count", int'(cnt[0]), 255);
        chk("sat_up_tc", int'(tcv[0]), 1);
        cyc(0, 1, 1, 0, 8'd0, 8'd5, 2'b01);
        chk("sat_again_count", int'(cnt[0]), 255);
        chk("sat_again_tc", int'(tcv[0]), 1);
        cyc(0, 0, 0, 1, 8'd2, 8'd5, 2'b01);
        cyc(0, 1, 0, 0, 8'd0, 8'd5, 2'b01);
        chk("sat_dn_count", int'(cnt[0]), 0);

        // One-shot (instance 0)
        cyc(0, 0, 1, 1, 8'd250, 8'd4, 2'b10);
        cyc(0, 1, 1, 0, 8'd0, 8'd4, 2'b10);
        chk("os_254", int'(cnt[0]), 254);
        chk("os_254_done", int'(dnv[0]), 0);
        cyc(0, 1, 1, 0, 8'd0, 8'd4, 2'b10);
        chk("os_255", int'(cnt[0]), 255);
        chk("os_tc", int'(tcv[0]), 1);
        chk("os_done", int'(dnv[0]), 1);
        cyc(0, 1, 0, 0, 8'd0, 8'd4, 2'b10);
        chk("os_frozen", int'(cnt[0]), 255);
        chk("os_frozen_tc", int'(tcv[0]), 0);
        cyc(0, 1, 0, 0, 8'd0, 8'd4, 2'b00);
        chk("os_sticky_done", int'(dnv[0]), 1);
        cyc(0, 0, 0, 1, 8'd3, 8'd4, 2'b10);
        chk("os_load_count", int'(cnt[0]), 3);
        chk("os_load_done", int'(dnv[0]), 0);

        // Prescaler (instance 2, PRESCALE=4): en 1,1,0,1,1
        cyc(0, 0, 1, 1, 8'd0, 8'd1, 2'b00);
        cyc(0, 1, 1, 0, 8'd0, 8'd1, 2'b00); chk("ps_e1", int'(cnt[2]), 0);
        cyc(0, 1, 1, 0, 8'd0, 8'd1, 2'b00); chk("ps_e2", int'(cnt[2]), 0);
        cyc(0, 0, 1, 0, 8'd0, 8'd1, 2'b00); chk("ps_off", int'(cnt[2]), 0);
        cyc(0, 1, 1, 0, 8'd0, 8'd1, 2'b00); chk("ps_e3", int'(cnt[2]), 0);
        cyc(0, 1, 1, 0, 8'd0, 8'd1, 2'b00); chk("ps_e4_tick", int'(cnt[2]), 1);
        // load mid-interval restarts the 4-cycle interval
        cyc(0, 1, 1, 0, 8'd0, 8'd1, 2'b00);
        cyc(0, 1, 1, 0, 8'd0, 8'd1, 2'b00);
        cyc(0, 1, 1, 1, 8'd5, 8'd1, 2'b00); chk("ps_load", int'(cnt[2]), 5);
        cyc(0, 1, 1, 0, 8'd0, 8'd1, 2'b00);
        cyc(0, 1, 1, 0, 8'd0, 8'd1, 2'b00);
        cyc(0, 1, 1, 0, 8'd0, 8'd1, 2'b00); chk("ps_restart_hold", int'(cnt[2]), 5);
        cyc(0, 1, 1, 0, 8'd0, 8'd1, 2'b00); chk("ps_restart_tick", int'(cnt[2]), 6);

        // Load clamp
        cyc(0, 0, 1, 1, 8'hFF, 8'd1, 2'b00);
        chk("clamp_99", int'(cnt[2]), 99);
        chk("clamp_9", int'(cnt[1]), 9);
        chk("clamp_255", int'(cnt[0]), 255);

        // Randomized stimulus, checked by the per-cycle model comparison
        for (int i = 0; i < 3000; i++) begin
            logic       r, e, u, l;
            logic [7:0] d, s;
            logic [1:0] m;
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = $urandom_range(0, 1) != 0;
            l = ($urandom_range(0, 11) == 0);
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 4))
                                            : 8'($urandom_range(0, 255));
            m = 2'($urandom_range(0, 3));
            cyc(r, e, u, l, d, s, m);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_count_up_down_mod
`default_nettype wire
